// File: rtl/wb_rr_arbiter.sv
// ============================================================================
// wb_rr_arbiter
//   Two-master, one-slave classic Wishbone round-robin arbiter with an
//   ack/err watchdog.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module wb_rr_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [DW/8-1:0]     m0_sel_i,
    input  logic [AW-1:0]       m0_adr_i,
    input  logic [DW-1:0]       m0_dat_i,
    output logic [DW-1:0]       m0_dat_o,
    output logic                m0_ack_o,
    output logic                m0_err_o,

    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [DW/8-1:0]     m1_sel_i,
    input  logic [AW-1:0]       m1_adr_i,
    input  logic [DW-1:0]       m1_dat_i,
    output logic [DW-1:0]       m1_dat_o,
    output logic                m1_ack_o,
    output logic                m1_err_o,

    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [DW/8-1:0]     s_sel_o,
    output logic [AW-1:0]       s_adr_o,
    output logic [DW-1:0]       s_dat_o,
    input  logic [DW-1:0]       s_dat_i,
    input  logic                s_ack_i,
    input  logic                s_err_i,

    output logic [1:0]          grant_o,
    output logic                timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;

    logic   w_own0, w_own1, w_own_stb;
    logic   w_wd_hit, w_wd_fire;

    assign w_own0    = (state_q == S_OWN0);
    assign w_own1    = (state_q == S_OWN1);
    assign w_own_stb = (w_own0 & m0_stb_i) | (w_own1 & m1_stb_i);

    // last_q names the previous owner, so a tie goes to the other master.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? S_OWN0 : S_OWN1;
                    last_d  = ~last_q;
                end else if (m0_cyc_i) begin
                    state_d = S_OWN0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = S_OWN1;
                    last_d  = 1'b1;
                end
            end
            S_OWN0:  if (!m0_cyc_i) state_d = S_IDLE;
            S_OWN1:  if (!m1_cyc_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_wd
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] wd_cnt_q, wd_cnt_d;

            always_comb begin
                wd_cnt_d = wd_cnt_q + 1'b1;
                if (!s_stb_o || s_ack_i || s_err_i || (state_d != state_q))
                    wd_cnt_d = '0;
            end

            always_ff @(posedge clk) begin
                if (!rst) wd_cnt_q <= '0;
                else      wd_cnt_q <= wd_cnt_d;
            end

            assign w_wd_hit = (wd_cnt_q == CW'(TIMEOUT));
        end else begin : g_no_wd
            assign w_wd_hit = 1'b0;
        end
    endgenerate

    // A slave ack in the expiry cycle wins, so s_stb_o depends on s_ack_i here.
    assign w_wd_fire = w_wd_hit & w_own_stb & ~s_ack_i;
    assign timeout_o = w_wd_fire;
    assign grant_o   = {w_own1, w_own0};

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (w_own0) begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i & ~w_wd_fire;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (w_own1) begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i & ~w_wd_fire;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

    assign m0_dat_o = w_own0 ? s_dat_i : '0;
    assign m1_dat_o = w_own1 ? s_dat_i : '0;
    assign m0_ack_o = s_ack_i & w_own0 & m0_stb_i;
    assign m1_ack_o = s_ack_i & w_own1 & m1_stb_i;
    assign m0_err_o = (s_err_i | w_wd_fire) & w_own0 & m0_stb_i;
    assign m1_err_o = (s_err_i | w_wd_fire) & w_own1 & m1_stb_i;

endmodule

`default_nettype wire

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Two-master, one-slave Wishbone (classic, non-pipelined) round-robin arbiter that shares the system RAM port in the atta SoC.
- Master 0 is the CPU data/instruction bus; master 1 is the debug/loader/DMA master.
- Ownership is held for the whole of a master's cyc_i assertion, so bursts and read-modify-write stay atomic.
- A watchdog terminates stalled slave cycles with a bus error so the CPU cannot hang forever.

Parameters:
AW, 32, address width
DW, 32, data width (multiple of 8); SW = DW/8 byte selects
TIMEOUT, 255, max wait cycles for slave ack/err while stb is high; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle/strobe/write
m0_sel_i  in  SW  master 0 byte selects
m0_adr_i  in  AW  master 0 address
m0_dat_i  in  DW  master 0 write data
m0_dat_o  out  DW  read data to master 0
m0_ack_o, m0_err_o  out  1 each  termination to master 0
m1_*  same set as m0_*  master 1
s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
s_sel_o  out  SW  to slave
s_adr_o  out  AW  to slave
s_dat_o  out  DW  to slave
s_dat_i  in  DW  slave read data
s_ack_i, s_err_i  in  1 each  slave termination
grant_o  out  2  one-hot current owner; 00 = bus idle
timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Clock and reset: clk, rising edge; reset rst, synchronous, active-low.
- Reset values:
  - state IDLE, grant_o=00, last_owner=1 (master 0 wins the first tie), wait counter 0.
  - All s_* control outputs 0, all m*_ack_o/err_o 0, timeout_o 0.
- States: IDLE, OWN0, OWN1 (registered).
- IDLE transitions:
  - only m0_cyc_i -> OWN0; only m1_cyc_i -> OWN1.
  - Both -> the master != last_owner. last_owner updates on entry to OWNx.
  - Arbitration latency: 1 cycle from cyc_i rising in IDLE to grant_o set.
- OWNx transitions:
  - Stay while mx_cyc_i=1, regardless of the other master.
  - mx_cyc_i=0 -> IDLE next edge. There is always ≥1 IDLE cycle between owners.
  - Re-arbitration happens in that IDLE cycle, so a master waiting continuously gets the bus 2 cycles after release.
- Slave-side outputs (combinational from the registered owner):
  - OWNx: s_cyc_o=mx_cyc_i; s_stb_o=mx_stb_i & ~wd_fire; s_we/sel/adr/dat_o = master x's.
  - IDLE: s_cyc_o=s_stb_o=s_we_o=0; s_sel/adr/dat_o=0.
- Master-side outputs:
  - mx_dat_o=s_dat_i for the owner, 0 otherwise.
  - mx_ack_o=s_ack_i & owner & mx_stb_i.
  - mx_err_o=(s_err_i | wd_fire) & owner & mx_stb_i.
  - A non-owner never sees ack/err.
  - A slave ack arriving in IDLE or after the owner drops stb is discarded.
- Watchdog (TIMEOUT>0):
  - Counter increments each cycle s_stb_o=1 with no s_ack_i/s_err_i.
  - Clears on ack, err, stb low, or state change.
  - wd_fire = (count == TIMEOUT), combinational. On wd_fire: owner gets err for that cycle, timeout_o=1, s_stb_o forced 0, counter clears next edge.
  - Saturation is impossible (width = clog2(TIMEOUT+1)).
  - TIMEOUT=0: wd_fire tied 0.
- Simultaneous events:
  - Slave ack in the same cycle as wd_fire: ack wins; no err, no timeout_o.
  - s_ack_i and s_err_i together are forwarded as-is.
- Reset mid-cycle: ownership is dropped immediately at the edge and the in-flight slave transfer is abandoned. The slave sees s_cyc_o=0 the next cycle.
- Masters dropping stb mid-wait is legal: counter clears, ownership is kept until cyc_i drops.

Test Plan:
- Single master: m0 writes 0xDEADBEEF to 0x100 (sel=1111), slave acks after 2 cycles.
  -> grant_o=01 one cycle after cyc; slave sees adr 0x100/data; m0_ack_o pulses once; m1_ack_o stays 0.
- Tie after reset: m0 and m1 raise cyc in the same cycle.
  -> m0 granted first; after m0 drops cyc, one IDLE cycle, then grant_o=10.
  -> Repeat the tie: m0 wins again only after m1's turn (strict alternation over 4 rounds: 01,10,01,10).
- Lock: m1 holds cyc across 3 back-to-back reads (0x0, 0x4, 0x8) while m0 requests.
  -> grant_o stays 10 for all three acks; m0 granted exactly 2 cycles after m1 releases cyc.
- Watchdog: TIMEOUT=4, slave never acks m0 read.
  -> On the 5th stb cycle (count=4), m0_err_o=1, timeout_o=1, s_stb_o=0 for one cycle; counter back to 0.
  -> With an ack on that same cycle instead: m0_ack_o=1, no err, no timeout_o.
- Reset mid-transfer: assert rst=0 while OWN1 with stb pending.
  -> Next cycle grant_o=00, s_cyc_o=0, no ack/err to either master.
  -> After release, m0 wins the first tie.
